// File: rtl/sixteen_by_four_mux.sv
// 16:1 bit selector built as a two-level tree of 4:1 sub-blocks with a registered output.
// Define SIXTEEN_BY_FOUR_MUX_PIPE_EN to register the leaf stage (latency 2 instead of 1).

module sixteen_by_four_mux_mux4 (
   input  logic [3:0] d,
   input  logic [1:0] sel,
   output logic       y
);
   // A case on sel reads only the selected bit, so unknowns on the other inputs never reach y.
   always_comb begin
      y = 1'b0;
      case (sel)
         2'd0:    y = d[0];
         2'd1:    y = d[1];
         2'd2:    y = d[2];
         2'd3:    y = d[3];
         default: y = 1'b0;
      endcase
   end
endmodule

module sixteen_by_four_mux #(
   parameter logic OUT_RST = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] data,
   input  logic [3:0]  select,
   input  logic        in_valid,
   output logic        out,
   output logic        out_valid
);
   logic [3:0] leaf_y;
   logic       root_y;
   logic       out_q, out_d;
   logic       out_valid_q, out_valid_d;

   for (genvar k = 0; k < 4; k++) begin : g_leaf
      sixteen_by_four_mux_mux4 u_leaf (
         .d   (data[4*k +: 4]),
         .sel (select[1:0]),
         .y   (leaf_y[k])
      );
   end

`ifdef SIXTEEN_BY_FOUR_MUX_PIPE_EN
   logic [3:0] leaf_q, leaf_d;
   logic [1:0] sel_hi_q, sel_hi_d;
   logic       v1_q, v1_d;

   sixteen_by_four_mux_mux4 u_root (
      .d   (leaf_q),
      .sel (sel_hi_q),
      .y   (root_y)
   );

   always_comb begin
      leaf_d      = leaf_y;
      sel_hi_d    = select[3:2];
      v1_d        = in_valid;
      out_d       = v1_q ? root_y : out_q;
      out_valid_d = v1_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         leaf_q      <= 4'd0;
         sel_hi_q    <= 2'd0;
         v1_q        <= 1'b0;
         out_q       <= OUT_RST;
         out_valid_q <= 1'b0;
      end else begin
         leaf_q      <= leaf_d;
         sel_hi_q    <= sel_hi_d;
         v1_q        <= v1_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end
`else
   sixteen_by_four_mux_mux4 u_root (
      .d   (leaf_y),
      .sel (select[3:2]),
      .y   (root_y)
   );

   always_comb begin
      out_d       = in_valid ? root_y : out_q;
      out_valid_d = in_valid;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q       <= OUT_RST;
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end
`endif

   assign out       = out_q;
   assign out_valid = out_valid_q;
endmodule

// File: tb/tb_sixteen_by_four_mux.sv
// Bench for sixteen_by_four_mux: directed tables, reset corners and random traffic vs. a delay-line model.
module tb_sixteen_by_four_mux;
   localparam logic TB_OUT_RST = 1'b1;
`ifdef SIXTEEN_BY_FOUR_MUX_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] data;
   logic [3:0]  select;
   logic        in_valid;
   logic        out;
   logic        out_valid;

   int checks = 0;
   int errors = 0;

   sixteen_by_four_mux #(.OUT_RST(TB_OUT_RST)) dut (
      .clk       (clk),
      .rst       (rst),
      .data      (data),
      .select    (select),
      .in_valid  (in_valid),
      .out       (out),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   // Model: accepted inputs travel through a queue LAT-1 deep; out holds the last emitted bit.
   logic [1:0] hist[$];
   logic       exp_out = TB_OUT_RST;
   logic       exp_valid = 1'b0;

   // Table expectations, consumed in order whenever the DUT raises out_valid.
   logic [0:0] exp_q[$];
   bit         table_mode = 1'b0;

   typedef struct {
      logic [15:0] data;
      logic [3:0]  sel;
      logic        exp;
   } vec_t;
   vec_t vecs[48];

   task automatic check(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
      end
   endtask

   task automatic reset_model();
      hist.delete();
      for (int i = 0; i < LAT - 1; i++) hist.push_back(2'b00);
      exp_out   = TB_OUT_RST;
      exp_valid = 1'b0;
   endtask

   task automatic cycle(input logic r, input logic [15:0] d, input logic [3:0] s,
                        input logic v, input logic sel_bit);
      logic [1:0] e;
      rst = r; data = d; select = s; in_valid = v;
      @(posedge clk);
      if (r) begin
         reset_model();
      end else begin
         hist.push_back({v, sel_bit});
         e = hist.pop_front();
         exp_valid = e[1];
         if (e[1]) exp_out = e[0];
      end
      #1;
      check("out_valid", out_valid, exp_valid);
      check("out", out, exp_out);
      if (table_mode && out_valid) begin
         if (exp_q.size() == 0) begin
            check("table_extra_valid", 1'b1, 1'b0);
         end else begin
            logic [0:0] x;
            x = exp_q.pop_front();
            check("table_out", out, x[0]);
         end
      end
   endtask

   task automatic drive(input logic r, input logic [15:0] d, input logic [3:0] s, input logic v);
      logic [15:0] dd;
      dd = d;
      cycle(r, d, s, v, dd[s]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 16'($urandom), 4'($urandom_range(0, 15)), 1'b0);
   endtask

   initial begin
      logic [15:0] sweep_data;
      logic [15:0] xd;
      logic [3:0]  s;
      logic        b;
      int          expected_seq[16];

      sweep_data   = 16'b1101001110100111;
      expected_seq = '{1, 1, 1, 0, 0, 1, 0, 1, 1, 1, 0, 0, 1, 0, 1, 1};
      for (int i = 0; i < 16; i++) begin
         vecs[i].data = sweep_data;
         vecs[i].sel  = 4'(i);
         vecs[i].exp  = expected_seq[i][0];
      end
      for (int i = 0; i < 16; i++) begin
         vecs[16 + 2*i].data = 16'(1) << i;
         vecs[16 + 2*i].sel  = 4'(i);
         vecs[16 + 2*i].exp  = 1'b1;
         vecs[17 + 2*i].data = 16'(1) << i;
         vecs[17 + 2*i].sel  = 4'((i + 1) % 16);
         vecs[17 + 2*i].exp  = 1'b0;
      end

      reset_model();
      // Reset release: two reset cycles, outputs at reset value.
      drive(1'b1, 16'hffff, 4'd3, 1'b1);
      drive(1'b1, 16'hffff, 4'd3, 1'b1);
      check("reset_out", out, TB_OUT_RST);
      check("reset_valid", out_valid, 1'b0);

      // Select sweep then walking one, back to back.
      table_mode = 1'b1;
      for (int i = 0; i < 48; i++) begin
         exp_q.push_back(vecs[i].exp);
         drive(1'b0, vecs[i].data, vecs[i].sel, 1'b1);
      end
      idle(LAT + 1);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL table_drain: %0d outputs missing, expected 0", exp_q.size());
      end
      exp_q.delete();
      table_mode = 1'b0;

      // Hold: inputs change with in_valid low, out must not move.
      drive(1'b0, 16'h0001, 4'd0, 1'b1);
      for (int i = 0; i < 6; i++) drive(1'b0, ~16'h0001, 4'($urandom_range(0, 15)), 1'b0);
      check("hold_out", out, 1'b1);

      // Reset mid-stream at select=7; in-flight selections must vanish.
      for (int i = 0; i < 7; i++) drive(1'b0, sweep_data, 4'(i), 1'b1);
      drive(1'b1, sweep_data, 4'd7, 1'b1);
      check("midrst_out", out, TB_OUT_RST);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, sweep_data, 4'd8, 1'b0);
         check("midrst_no_valid", out_valid, 1'b0);
      end
      // First input after reset is accepted on the first edge.
      drive(1'b0, sweep_data, 4'd3, 1'b1);
      idle(LAT);
      check("post_rst_out", out, 1'b0);

      // Unknowns on unselected bits do not affect the result.
      for (int i = 0; i < 8; i++) begin
         s  = 4'($urandom_range(0, 15));
         b  = 1'($urandom);
         xd = 'x;
         xd[s] = b;
         cycle(1'b0, xd, s, 1'b1, b);
      end
      idle(LAT);

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 31) == 0, 16'($urandom), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 3) != 0));
      end
      idle(LAT + 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sixteen_by_four_mux.md
SIXTEEN_BY_FOUR_MUX -- requirements
Module: sixteen_by_four_mux

Interface
REQ-001 Parameter OUT_RST, default 1'b0: value driven on out while reset is applied.
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1: synchronous, active-high reset.
REQ-004 Port data, input, 16: data word to select from; bit i is candidate i.
REQ-005 Port select, input, 4: unsigned index of the data bit to route.
REQ-006 Port in_valid, input, 1: data and select are valid this cycle.
REQ-007 Port out, output, 1: registered selected bit.
REQ-008 Port out_valid, output, 1: out holds a freshly selected bit.
REQ-009 Port order SHALL be clk, rst, data, select, in_valid, out, out_valid.

Function
REQ-010 The selected bit SHALL equal data[select] for all 16 select values; select=0 picks data[0], and select=15 picks data[15].
REQ-011 Selection SHALL be built as a two-level tree of five identical 4:1 mux sub-blocks, each with a 2-bit select.
REQ-012 Leaf k (k=0..3) SHALL take data[4k+3:4k] with select[1:0]; the root SHALL take the four leaf outputs with select[3:2].
REQ-013 Each 4:1 sub-block SHALL be purely combinational, with no latches.
REQ-014 Default build: on a clk edge with in_valid=1, out SHALL load data[select]; latency is 1 cycle from input to out.
REQ-015 Default build: on a clk edge with in_valid=0, out SHALL hold its previous value.
REQ-016 out_valid SHALL be in_valid delayed by the build's latency, and SHALL assert for exactly one cycle per accepted input.
REQ-017 Throughput SHALL be one selection per cycle; back-to-back in_valid SHALL produce back-to-back out_valid.
REQ-018 X/Z on unselected data bits SHALL NOT affect out.

Reset
REQ-019 While rst=1 at a clk edge: out SHALL be OUT_RST, out_valid SHALL be 0, and all pipeline state SHALL clear.
REQ-020 rst SHALL take priority over a simultaneous in_valid; that input is discarded.
REQ-021 Reset applied mid-operation SHALL discard all in-flight selections; no out_valid SHALL follow for them.
REQ-022 After rst deasserts, the first in_valid SHALL be accepted on the same edge.

Configuration
REQ-023 Macro SIXTEEN_BY_FOUR_MUX_PIPE_EN, when defined, SHALL add registers on the four leaf outputs, plus select[3:2] and a valid bit delayed one cycle.
REQ-024 With the macro defined, latency SHALL be 2 cycles, throughput SHALL remain 1 per cycle, and out SHALL hold when the stage-2 valid is 0.
REQ-025 Without the macro, the design SHALL be the single-register form of REQ-014; ports and function are otherwise identical.

Verification
REQ-026 Bench SHALL cover these directed scenarios:
- Reset release -> rst=1 for 2 cycles -> out=OUT_RST, out_valid=0.
- Select sweep -> data=16'b1101001110100111, select 0..15 with in_valid=1 each cycle -> out sequence 1,1,1,0,0,1,0,1,1,1,0,0,1,0,1,1 after the build latency, with out_valid=1 throughout.
- Hold -> in_valid=0 while data/select change -> out unchanged, out_valid=0.
- Walking one -> data=1<<i with select=i -> out=1; with select=(i+1)%16 -> out=0, for all i.
- Reset mid-stream -> rst during the sweep at select=7 -> no out_valid for in-flight inputs; out=OUT_RST.
- Both builds -> run the sweep with and without SIXTEEN_BY_FOUR_MUX_PIPE_EN -> latency 1 vs 2, identical out sequence.
